// File: rtl/if2_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// if2_fetch_queue_if
//   Bundles the IF2 fetch-queue traffic. This covers the IF1 request
//   (pc_reg, icache_re, if1_adef), the I-cache response (icache_rvalid,
//   icache_rdata), the backend flush, the pc_wen credit back to IF1, and the
//   valid/ready hand-off to ID (id_valid, id_ready, id_pc, id_inst, id_adef).
//   master : the surroundings (IF1, I-cache, backend, ID) driving the queue.
//   slave  : the fetch queue itself.
// ---------------------------------------------------------------------------
interface if2_fetch_queue_if;
  logic [31:0] pc_reg;
  logic        icache_re;
  logic        if1_adef;
  logic        icache_rvalid;
  logic [31:0] icache_rdata;
  logic        flush;
  logic        pc_wen;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_adef;

  modport master (
    output pc_reg, icache_re, if1_adef, icache_rvalid, icache_rdata, flush, id_ready,
    input  pc_wen, id_valid, id_pc, id_inst, id_adef
  );

  modport slave (
    input  pc_reg, icache_re, if1_adef, icache_rvalid, icache_rdata, flush, id_ready,
    output pc_wen, id_valid, id_pc, id_inst, id_adef
  );
endinterface

// File: rtl/if2_fetch_queue.sv
// ---------------------------------------------------------------------------
// if2_fetch_queue
//   IF2 in-order fetch queue. Each IF1 request gets a slot at the tail. The
//   I-cache's in-order responses fill slots at the fill pointer. The head
//   slot is presented to ID once it is filled. After a flush, the responses
//   still owed for wrong-path requests are counted in drop_cnt and discarded
//   as they come back.
//
// Ports:
//   clk    : clock, all state updates on posedge
//   rst_n  : synchronous active-low reset
//   bus    : if2_fetch_queue_if.slave (request, response, flush, credit, ID)
//
// Parameters:
//   DEPTH    : number of slots, power of two, >= 2
//   NOP_INST : word presented to ID for address-error (adef) entries
//
// Optional feature (macro FETCH_QUEUE_BYPASS_EN):
//   When it is defined, a response destined for an unfilled head slot is
//   forwarded to ID in the same cycle. When it is undefined, the id_* outputs
//   come from the slot registers only, and the minimum response-to-ID
//   latency is one cycle.
// ---------------------------------------------------------------------------
module if2_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h0340_0000
) (
  input logic              clk,
  input logic              rst_n,
  if2_fetch_queue_if.slave bus
);

  localparam int unsigned   PW      = $clog2(DEPTH);
  localparam int unsigned   CW      = PW + 1;   // count: 0..DEPTH
  localparam int unsigned   DW      = PW + 2;   // drop_cnt: 0..DEPTH+1 with headroom
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DEPTH-1:0][31:0] pc_q, pc_d;
  logic [DEPTH-1:0][31:0] inst_q, inst_d;
  logic [DEPTH-1:0]       adef_q, adef_d;
  logic [DEPTH-1:0]       filled_q, filled_d;
  logic [PW-1:0]          head_q, head_d;
  logic [PW-1:0]          fill_q, fill_d;
  logic [PW-1:0]          tail_q, tail_d;
  logic [CW-1:0]          count_q, count_d;
  logic [DW-1:0]          drop_q, drop_d;

  logic [CW-1:0] filled_cnt_s;
  logic [CW-1:0] unfilled_s;
  logic          head_filled_s;
  logic          bypass_s;
  logic          id_valid_s;
  logic          pop_s;
  logic          alloc_s;
  logic          drop_hit_s;
  logic          fill_s;
  logic          fill_write_s;
  logic          pc_wen_s;
  logic [31:0]   id_inst_s;

  // Queue status, handshake decode and credit
  always_comb begin
    // Allocated-unfilled = count minus filled slots. This also covers the
    // full-and-unfilled case, where tail == fill would otherwise read as zero.
    filled_cnt_s = {CW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      filled_cnt_s = filled_cnt_s + {{(CW-1){1'b0}}, filled_q[i]};
    end
    unfilled_s    = count_q - filled_cnt_s;
    head_filled_s = filled_q[head_q];
    drop_hit_s    = bus.icache_rvalid && (drop_q != {DW{1'b0}});
    fill_s        = bus.icache_rvalid && !drop_hit_s && !bus.flush;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass_s = (count_q != {CW{1'b0}}) && !head_filled_s && (drop_q == {DW{1'b0}}) &&
               !bus.flush && bus.icache_rvalid && (fill_q == head_q);
`else
    bypass_s = 1'b0;
`endif
    id_valid_s = !bus.flush && (head_filled_s || bypass_s);
    pop_s      = id_valid_s && bus.id_ready;
    alloc_s    = bus.icache_re && !bus.flush && (count_q != DEPTH_C);
    // A bypassed entry that ID takes immediately is never written.
    fill_write_s = fill_s && !(bypass_s && bus.id_ready);
    // Conservative credit: ignores a same-cycle pop.
    pc_wen_s = bus.flush ||
               (({1'b0, count_q} + {{CW{1'b0}}, bus.icache_re}) < {1'b0, DEPTH_C});
    if (bypass_s) begin
      id_inst_s = adef_q[head_q] ? NOP_INST : bus.icache_rdata;
    end else begin
      id_inst_s = inst_q[head_q];
    end
  end

  // Next-state for slots, pointers and counters
  always_comb begin
    pc_d     = pc_q;
    inst_d   = inst_q;
    adef_d   = adef_q;
    filled_d = filled_q;
    head_d   = head_q;
    fill_d   = fill_q;
    tail_d   = tail_q;
    count_d  = count_q;
    drop_d   = drop_q;
    if (bus.flush) begin
      filled_d = {DEPTH{1'b0}};
      head_d   = {PW{1'b0}};
      fill_d   = {PW{1'b0}};
      tail_d   = {PW{1'b0}};
      count_d  = {CW{1'b0}};
      // Every response still owed for a discarded or same-cycle request will
      // be dropped. A response arriving now already settles one of them.
      drop_d = drop_q + {{(DW-CW){1'b0}}, unfilled_s}
                      + {{(DW-1){1'b0}}, bus.icache_re}
                      - {{(DW-1){1'b0}}, bus.icache_rvalid};
    end else begin
      if (alloc_s) begin
        pc_d[tail_q]     = bus.pc_reg;
        adef_d[tail_q]   = bus.if1_adef;
        filled_d[tail_q] = 1'b0;
        tail_d           = tail_q + PW'(1);
      end else begin
        tail_d = tail_q;
      end
      if (pop_s) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + PW'(1);
      end else begin
        head_d = head_q;
      end
      if (drop_hit_s) begin
        drop_d = drop_q - DW'(1);
      end else begin
        drop_d = drop_q;
      end
      if (fill_s) begin
        // An adef entry still consumes its response. It stores NOP so the
        // head mux needs no adef check.
        if (fill_write_s) begin
          inst_d[fill_q]   = adef_q[fill_q] ? NOP_INST : bus.icache_rdata;
          filled_d[fill_q] = 1'b1;
        end else begin
          inst_d[fill_q] = inst_q[fill_q];
        end
        fill_d = fill_q + PW'(1);
      end else begin
        fill_d = fill_q;
      end
      count_d = count_q + {{(CW-1){1'b0}}, alloc_s} - {{(CW-1){1'b0}}, pop_s};
    end
  end

  // State registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= {(DEPTH*32){1'b0}};
      inst_q   <= {(DEPTH*32){1'b0}};
      adef_q   <= {DEPTH{1'b0}};
      filled_q <= {DEPTH{1'b0}};
      head_q   <= {PW{1'b0}};
      fill_q   <= {PW{1'b0}};
      tail_q   <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      drop_q   <= {DW{1'b0}};
    end else begin
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      adef_q   <= adef_d;
      filled_q <= filled_d;
      head_q   <= head_d;
      fill_q   <= fill_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  assign bus.pc_wen   = pc_wen_s;
  assign bus.id_valid = id_valid_s;
  assign bus.id_pc    = pc_q[head_q];
  assign bus.id_inst  = id_inst_s;
  assign bus.id_adef  = adef_q[head_q];

endmodule

// File: tb/tb_if2_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_if2_fetch_queue
//   Drives the fetch queue through directed scenarios and a randomized run.
//   Expected outputs come from a queue-level reference model. That model
//   keeps a list of pending requests, a list of completed entries, a drop
//   counter and an I-cache outstanding counter.
// ---------------------------------------------------------------------------
module tb_if2_fetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0340_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_rn, i_re, i_adef, i_rv, i_fl, i_rdy;
  logic [31:0] i_pc, i_rd;

  if2_fetch_queue_if bus();
  assign bus.pc_reg        = i_pc;
  assign bus.icache_re     = i_re;
  assign bus.if1_adef      = i_adef;
  assign bus.icache_rvalid = i_rv;
  assign bus.icache_rdata  = i_rd;
  assign bus.flush         = i_fl;
  assign bus.id_ready      = i_rdy;

  if2_fetch_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk   (clk),
    .rst_n (i_rn),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  ent_t pend[$];
  ent_t rdy[$];
  int   drop   = 0;
  int   ic_out = 0;
  ent_t dut_log[$];

  logic        exp_valid, exp_wen, exp_byp, exp_adef;
  logic [31:0] exp_pc, exp_inst;

  function automatic void model_expect();
    int tot;
    tot       = pend.size() + rdy.size();
    exp_wen   = i_fl || ((tot + int'(i_re)) < DEPTH);
    exp_byp   = 1'b0;
    exp_valid = 1'b0;
    exp_pc    = 32'h0;
    exp_inst  = 32'h0;
    exp_adef  = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (rdy.size() == 0 && pend.size() > 0 && drop == 0 && !i_fl && i_rv) exp_byp = 1'b1;
`endif
    if (!i_fl) begin
      if (rdy.size() > 0) begin
        exp_valid = 1'b1;
        exp_pc    = rdy[0].pc;
        exp_inst  = rdy[0].inst;
        exp_adef  = rdy[0].adef;
      end else if (exp_byp) begin
        exp_valid = 1'b1;
        exp_pc    = pend[0].pc;
        exp_adef  = pend[0].adef;
        exp_inst  = pend[0].adef ? NOP : i_rd;
      end
    end
  endfunction

  function automatic void model_update();
    ent_t e;
    int   tot;
    if (!i_rn) begin
      pend.delete();
      rdy.delete();
      drop   = 0;
      ic_out = 0;
    end else begin
      tot    = pend.size() + rdy.size();
      ic_out = ic_out + int'(i_re) - int'(i_rv);
      if (i_fl) begin
        drop = drop + pend.size() + int'(i_re) - int'(i_rv);
        pend.delete();
        rdy.delete();
      end else begin
        if (exp_valid && i_rdy && !exp_byp) void'(rdy.pop_front());
        if (exp_byp && i_rdy) begin
          void'(pend.pop_front());
        end else if (i_rv) begin
          if (drop > 0) drop--;
          else if (pend.size() > 0) begin
            e      = pend.pop_front();
            e.inst = e.adef ? NOP : i_rd;
            rdy.push_back(e);
          end
        end
        if (i_re && tot < DEPTH) pend.push_back('{pc: i_pc, inst: 32'h0, adef: i_adef});
      end
    end
  endfunction

  task automatic apply(input logic rn, input logic re, input logic [31:0] pc, input logic adef,
                       input logic rv, input logic [31:0] rd, input logic fl, input logic rdy_in);
    @(negedge clk);
    i_rn = rn; i_re = re; i_pc = pc; i_adef = adef;
    i_rv = rv; i_rd = rd; i_fl = fl; i_rdy = rdy_in;
    #1;
    model_expect();
    if (bus.id_valid === 1'b1 && rdy_in && rn) dut_log.push_back('{pc: bus.id_pc, inst: bus.id_inst, adef: bus.id_adef});
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
  endtask

  task automatic drain();
    for (int c = 0; c < 40; c++) begin
      if (ic_out == 0 && pend.size() == 0 && rdy.size() == 0) break;
      apply(1'b1, 1'b0, 32'h0, 1'b0, ic_out > 0, 32'h0, 1'b0, 1'b1);
      tick();
    end
    dut_log.delete();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
    end
    apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (bus.id_valid !== 1'b0 || bus.id_pc !== 32'h0 || bus.id_inst !== 32'h0 ||
        bus.id_adef !== 1'b0 || bus.pc_wen !== 1'b1)
    begin
      errors++;
      $display("FAIL reset got valid=%b pc=%h inst=%h adef=%b wen=%b want 0/0/0/0/1",
               bus.id_valid, bus.id_pc, bus.id_inst, bus.id_adef, bus.pc_wen);
    end
    tick();
  endtask

  task automatic test_basic_order();
    dut_log.delete();
    for (int c = 0; c < 7; c++) begin
      apply(1'b1, c < 3, 32'h1c00_0000 + 32'(4 * c), 1'b0, c >= 1 && c <= 3, 32'(17 * c), 1'b0, 1'b1);
      checks++;
      if (bus.id_valid !== exp_valid || bus.pc_wen !== 1'b1) begin
        errors++;
        $display("FAIL basic_hs c=%0d valid=%b want %b pc_wen=%b want 1", c, bus.id_valid, exp_valid, bus.pc_wen);
      end
      if (exp_valid) begin
        checks++;
        if (bus.id_pc !== exp_pc || bus.id_inst !== exp_inst || bus.id_adef !== exp_adef) begin
          errors++;
          $display("FAIL basic_head got %h/%h/%b want %h/%h/%b", bus.id_pc, bus.id_inst, bus.id_adef, exp_pc, exp_inst, exp_adef);
        end
      end
      tick();
    end
    checks++;
    if (dut_log.size() != 3) begin
      errors++;
      $display("FAIL basic_count got %0d want 3", dut_log.size());
    end
    for (int k = 0; k < 3 && k < dut_log.size(); k++) begin
      checks++;
      if (dut_log[k].pc !== 32'h1c00_0000 + 32'(4 * k) || dut_log[k].inst !== 32'(17 * (k + 1))) begin
        errors++;
        $display("FAIL basic_order k=%0d got %h/%h want %h/%h", k, dut_log[k].pc, dut_log[k].inst,
                 32'h1c00_0000 + 32'(4 * k), 32'(17 * (k + 1)));
      end
    end
    drain();
  endtask

  task automatic test_full_stall();
    logic re, rv, rd_y, want_wen;
    dut_log.delete();
    for (int c = 0; c < 7; c++) begin
      re   = c < 4;
      rv   = c >= 1 && c <= 4;
      rd_y = c == 5;
      want_wen = !(c >= 3 && c <= 5);
      apply(1'b1, re, 32'h1c00_0020 + 32'(4 * c), 1'b0, rv, 32'ha0 + 32'(c), 1'b0, rd_y);
      checks++;
      if (bus.pc_wen !== want_wen || bus.pc_wen !== exp_wen || bus.id_valid !== exp_valid) begin
        errors++;
        $display("FAIL full_credit c=%0d pc_wen=%b want %b valid=%b want %b", c, bus.pc_wen, want_wen, bus.id_valid, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (bus.id_pc !== exp_pc || bus.id_inst !== exp_inst) begin
          errors++;
          $display("FAIL full_head got %h/%h want %h/%h", bus.id_pc, bus.id_inst, exp_pc, exp_inst);
        end
      end
      tick();
    end
    checks++;
    if (dut_log.size() != 1 || (dut_log.size() > 0 && dut_log[0].pc !== 32'h1c00_0020)) begin
      errors++;
      $display("FAIL full_pop got %0d pops want 1 at 1c000020", dut_log.size());
    end
    drain();
  endtask

  task automatic test_flush();
    logic re, rv, fl;
    logic [31:0] pc, rd;
    dut_log.delete();
    for (int c = 0; c < 12; c++) begin
      re = c <= 4;
      fl = c == 3;
      pc = (c == 4) ? 32'h1c00_0100 : 32'h1c00_0040 + 32'(4 * c);
      rv = c >= 4 && c <= 8;
      rd = (c == 8) ? 32'h1234_5678 : 32'hbad0_0000 + 32'(c);
      apply(1'b1, re, pc, 1'b0, rv, rd, fl, 1'b1);
      checks++;
      if (bus.id_valid !== exp_valid || bus.pc_wen !== exp_wen || (fl && (bus.pc_wen !== 1'b1 || bus.id_valid !== 1'b0))) begin
        errors++;
        $display("FAIL flush_hs c=%0d valid=%b want %b pc_wen=%b want %b", c, bus.id_valid, exp_valid, bus.pc_wen, exp_wen);
      end
      if (exp_valid) begin
        checks++;
        if (bus.id_pc !== exp_pc || bus.id_inst !== exp_inst) begin
          errors++;
          $display("FAIL flush_head got %h/%h want %h/%h", bus.id_pc, bus.id_inst, exp_pc, exp_inst);
        end
      end
      tick();
    end
    checks++;
    if (dut_log.size() != 1 || (dut_log.size() > 0 &&
        (dut_log[0].pc !== 32'h1c00_0100 || dut_log[0].inst !== 32'h1234_5678))) begin
      errors++;
      $display("FAIL flush_drop got %0d entries (first %h/%h) want 1 entry 1c000100/12345678",
               dut_log.size(), dut_log.size() > 0 ? dut_log[0].pc : 32'h0, dut_log.size() > 0 ? dut_log[0].inst : 32'h0);
    end
    drain();
  endtask

  task automatic test_adef();
    dut_log.delete();
    for (int c = 0; c < 4; c++) begin
      apply(1'b1, c == 0, 32'h1c00_0002, c == 0, c == 1, 32'hdead_beef, 1'b0, 1'b1);
      checks++;
      if (bus.id_valid !== exp_valid || bus.pc_wen !== exp_wen) begin
        errors++;
        $display("FAIL adef_hs c=%0d valid=%b want %b", c, bus.id_valid, exp_valid);
      end
      tick();
    end
    checks++;
    if (dut_log.size() != 1 || (dut_log.size() > 0 &&
        (dut_log[0].pc !== 32'h1c00_0002 || dut_log[0].inst !== NOP || dut_log[0].adef !== 1'b1))) begin
      errors++;
      $display("FAIL adef_entry got %0d entries (first %h/%h/%b) want 1c000002/03400000/1", dut_log.size(),
               dut_log.size() > 0 ? dut_log[0].pc : 32'h0, dut_log.size() > 0 ? dut_log[0].inst : 32'h0,
               dut_log.size() > 0 ? dut_log[0].adef : 1'b0);
    end
    drain();
  endtask

  task automatic test_wrap();
    int k = 0;
    int r = 0;
    logic re, rv;
    dut_log.delete();
    for (int c = 0; c < 200 && dut_log.size() < 10; c++) begin
      re = (k < 10) && (pend.size() + rdy.size() < DEPTH);
      rv = ic_out > 0;
      apply(1'b1, re, 32'h1c00_0200 + 32'(4 * k), 1'b0, rv, 32'ha000_0000 + 32'(r), 1'b0, (c % 2) == 0);
      checks++;
      if (bus.id_valid !== exp_valid || bus.pc_wen !== exp_wen) begin
        errors++;
        $display("FAIL wrap_hs c=%0d valid=%b want %b pc_wen=%b want %b", c, bus.id_valid, exp_valid, bus.pc_wen, exp_wen);
      end
      tick();
      if (re) k++;
      if (rv) r++;
    end
    checks++;
    if (dut_log.size() != 10) begin
      errors++;
      $display("FAIL wrap_count got %0d want 10", dut_log.size());
    end
    for (int j = 0; j < dut_log.size() && j < 10; j++) begin
      checks++;
      if (dut_log[j].pc !== 32'h1c00_0200 + 32'(4 * j) || dut_log[j].inst !== 32'ha000_0000 + 32'(j)) begin
        errors++;
        $display("FAIL wrap_order j=%0d got %h/%h want %h/%h", j, dut_log[j].pc, dut_log[j].inst,
                 32'h1c00_0200 + 32'(4 * j), 32'ha000_0000 + 32'(j));
      end
    end
    drain();
  endtask

`ifdef FETCH_QUEUE_BYPASS_EN
  task automatic test_bypass();
    for (int c = 0; c < 3; c++) begin
      apply(1'b1, c == 0, 32'h1c00_0010, 1'b0, c == 1, 32'h0000_0055, 1'b0, 1'b1);
      checks++;
      if (c == 1 && (bus.id_valid !== 1'b1 || bus.id_inst !== 32'h55 || bus.id_pc !== 32'h1c00_0010)) begin
        errors++;
        $display("FAIL bypass_fwd got %b/%h/%h want 1/1c000010/00000055", bus.id_valid, bus.id_pc, bus.id_inst);
      end else if (c != 1 && (bus.id_valid !== 1'b0 || bus.pc_wen !== 1'b1)) begin
        errors++;
        $display("FAIL bypass_empty c=%0d valid=%b want 0 pc_wen=%b want 1", c, bus.id_valid, bus.pc_wen);
      end
      tick();
    end
    drain();
  endtask
`else
  task automatic test_latency();
    for (int c = 0; c < 4; c++) begin
      apply(1'b1, c == 0, 32'h1c00_0010, 1'b0, c == 1, 32'h0000_0055, 1'b0, 1'b1);
      checks++;
      if (bus.id_valid !== (c == 2) || (c == 2 && bus.id_inst !== 32'h55)) begin
        errors++;
        $display("FAIL latency c=%0d valid=%b inst=%h want valid=%b inst=00000055", c, bus.id_valid, bus.id_inst, c == 2);
      end
      tick();
    end
    drain();
  endtask
`endif

  task automatic test_random();
    logic        re, rv, fl, adef, rdy_in;
    logic [31:0] pc;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      end else begin
        fl     = $urandom_range(0, 19) == 0;
        re     = (fl || (pend.size() + rdy.size() < DEPTH)) && ($urandom_range(0, 2) != 0);
        adef   = $urandom_range(0, 7) == 0;
        pc     = $urandom();
        pc[1:0] = adef ? 2'b10 : 2'b00;
        rv     = (ic_out > 0) && ($urandom_range(0, 2) != 0);
        rdy_in = $urandom_range(0, 3) != 0;
        apply(1'b1, re, pc, adef, rv, $urandom(), fl, rdy_in);
      end
      checks++;
      if (bus.id_valid !== exp_valid || bus.pc_wen !== exp_wen) begin
        errors++;
        $display("FAIL rand_hs c=%0d valid=%b want %b pc_wen=%b want %b", c, bus.id_valid, exp_valid, bus.pc_wen, exp_wen);
      end
      if (exp_valid) begin
        checks++;
        if (bus.id_pc !== exp_pc || bus.id_inst !== exp_inst || bus.id_adef !== exp_adef) begin
          errors++;
          $display("FAIL rand_head c=%0d got %h/%h/%b want %h/%h/%b", c, bus.id_pc, bus.id_inst, bus.id_adef,
                   exp_pc, exp_inst, exp_adef);
        end
      end
      tick();
    end
  endtask

  initial begin
    i_rn = 1'b0; i_re = 1'b0; i_pc = 32'h0; i_adef = 1'b0;
    i_rv = 1'b0; i_rd = 32'h0; i_fl = 1'b0; i_rdy = 1'b0;
    test_reset();
    test_basic_order();
    test_full_stall();
    test_flush();
    test_adef();
    test_wrap();
`ifdef FETCH_QUEUE_BYPASS_EN
    test_bypass();
`else
    test_latency();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/if2_fetch_queue.md
Name: if2_fetch_queue

Overview:
- IF2-stage fetch queue; the response side of the IF1 PC generator's fetch-request interface.
- Allocates an in-order slot for each fetch request (pc, icache_re, if1_adef) and fills it with the I-cache's in-order response. Presents completed entries to ID with a valid/ready handshake.
- Drives pc_wen back to the PC generator as a credit/stall signal, and discards wrong-path requests and responses on flush.

Parameters:
- DEPTH, 4, number of queue slots; power of two, >= 2.
- NOP_INST, 32'h0340_0000, instruction word presented for address-error (adef) entries.

Ports:
- clk  input  1  clock; all state updates on posedge clk.
- rst_n  input  1  reset, synchronous, active-low.
- pc_reg  input  32  PC of the current fetch request.
- icache_re  input  1  fetch request valid this cycle (registered pc_wen from IF1).
- if1_adef  input  1  request PC misaligned (pc_reg[1:0] != 0).
- icache_rvalid  input  1  I-cache response valid; responses return in request order, latency >= 1.
- icache_rdata  input  32  I-cache response instruction word.
- flush  input  1  backend redirect (same cycle as pc_is_wrong to IF1).
- pc_wen  output  1  PC generator may advance / issue next request.
- id_valid  output  1  head entry complete and presented to ID.
- id_ready  input  1  ID accepts the head entry.
- id_pc  output  32  PC of the head entry.
- id_inst  output  32  instruction of the head entry; NOP_INST when id_adef=1.
- id_adef  output  1  head entry carries an instruction-fetch address exception.

Behaviour:
- Storage: ring of DEPTH slots {pc, inst, adef, filled}.
- Pointers: head (pop), fill (next unfilled), tail (alloc), each log2(DEPTH) bits, wrapping modulo DEPTH.
- Counters: count (0..DEPTH) and drop_cnt (0..DEPTH+1).
- Reset (rst_n=0 at posedge): pointers, count, drop_cnt and all filled bits = 0. id_valid=0; id_pc, id_inst, id_adef = 0. Reset mid-operation abandons all outstanding responses; the I-cache is reset together with this block.
- Alloc: when icache_re=1 and flush=0, write {pc_reg, if1_adef, filled=0} at tail; tail++.
  - icache_re with count==DEPTH is a protocol violation: ignored, no state change.
- Fill:
  - icache_rvalid=1 and drop_cnt>0: response discarded, drop_cnt--.
  - Otherwise, with flush=0: write icache_rdata to slot fill, set filled; fill++.
  - Adef entries still consume one response; its data is ignored.
- Pop: id_valid = filled[head]. id_pc, id_inst, id_adef are driven from the head slot. When id_valid & id_ready & !flush: clear filled[head]; head++.
- count_next = count + alloc - pop; alloc, fill and pop may all occur in one cycle, including at count==DEPTH-1 and at pointer wrap.
- Credit: pc_wen = flush | ((count + icache_re) < DEPTH). This is combinational and conservative (ignores same-cycle pop), so no slot is ever over-allocated given IF1's one-cycle request pipeline.
- Flush (highest priority):
  - At the edge, clear all slots, pointers and count.
  - drop_cnt_next = drop_cnt + (allocated-unfilled entries) + icache_re - icache_rvalid, where allocated-unfilled = tail - fill (mod DEPTH; DEPTH when the queue is full and unfilled).
  - The same-cycle request is wrong-path and counted for drop; a same-cycle response is discarded.
  - id_valid is forced 0 during the flush cycle.
  - pc_wen=1 during flush, so IF1 loads pc_correct.
- After flush, no new entry fills until drop_cnt reaches 0. New allocations proceed immediately.
- Latency: a response filling the head slot gives id_valid=1 in the next cycle.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined: when the head slot is unfilled, drop_cnt==0, flush=0 and icache_rvalid=1 with fill==head, the response is forwarded combinationally. id_valid=1 in the same cycle, with id_inst=icache_rdata (NOP_INST if adef).
  - If id_ready=1, the entry pops without its filled bit ever being set.
  - If id_ready=0, it is written as normal.
- Not defined: the minimum response-to-ID latency is 1 cycle and id_* outputs are purely register-driven.

Test Plan:
- Reset, then requests at pc 1c00_0000/04/08, responses 0x11/0x22/0x33 on the next three cycles, id_ready=1 -> ID sees (1c00_0000,0x11), (04,0x22), (08,0x33) in order; pc_wen stays 1.
- id_ready=0, issue requests until full (DEPTH=4) -> pc_wen=0 once count+icache_re reaches 4. Then id_ready=1 for one cycle -> exactly one pop; pc_wen returns to 1 the following cycle.
- 3 requests outstanding and unfilled, flush with icache_re=1 -> drop_cnt=4. The next 4 responses are discarded. The first post-flush request at pc_correct=1c00_0100 appears on ID with the 5th response.
- Request with if1_adef=1 at pc 1c00_0002, response 0xdeadbeef -> id_adef=1, id_pc=1c00_0002, id_inst=0340_0000.
- Pointer wrap: 10 back-to-back requests/responses with id_ready toggling 1,0,1,0 -> all 10 delivered in order with no loss or duplication; count never exceeds 4.
- With FETCH_QUEUE_BYPASS_EN, empty queue, response 0x55 at pc 1c00_0010 with id_ready=1 -> id_valid=1 in the response cycle, and the queue stays empty.
